// File: rtl/ctrl_pkg.sv
// Shared control-decode definitions: funct codes, ALU select codes, occupancy states, control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000001;

    // ALU operation selects (base 3-bit encoding)
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_SRL = 3'd4;

    localparam logic [5:0] OP_NOP = 6'd0;

    // The control word carries the base 3-bit ALU select; wider consumers zero-extend it.
    typedef struct packed {
        logic       reg_write;
        logic       alu_to_reg;
        logic       alu_op;
        logic [2:0] alu_cntrl;
        logic       illegal;
    } ctrl_word_t;

    // Skid-buffer occupancy: ONE means only the output register holds an entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/fn_code decoder producing a ctrl_word_t; flags undefined encodings as illegal.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports are opcode, fn_code in and word out.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int              OP_W     = 6,
    parameter int              FN_W     = 6,
    parameter logic [OP_W-1:0] RTYPE_OP = '1
) (
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] fn_code,
    output ctrl_word_t      word
);

    ctrl_word_t illegal_word;

    always_comb begin
        illegal_word         = '0;
        illegal_word.illegal = 1'b1;
    end

    always_comb begin
        word = '0;
        if (opcode == RTYPE_OP) begin
            word.reg_write  = 1'b1;
            word.alu_to_reg = 1'b1;
            word.alu_op     = 1'b1;
            case (fn_code)
                FN_W'(FN_ADD): word.alu_cntrl = ALU_ADD;
                FN_W'(FN_SUB): word.alu_cntrl = ALU_SUB;
                FN_W'(FN_AND): word.alu_cntrl = ALU_AND;
                FN_W'(FN_OR):  word.alu_cntrl = ALU_OR;
                FN_W'(FN_SLL): word.alu_cntrl = ALU_SLL;
                FN_W'(FN_SRL): word.alu_cntrl = ALU_SRL;
                default:       word = illegal_word;
            endcase
        end else if (opcode == OP_W'(OP_NOP)) begin
            word = '0;
        end else begin
            word = illegal_word;
        end
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered control decoder: valid/ready in, 2-entry skid buffer out, flush, saturating illegal counter.
// Latency: 1 cycle from input transfer to out_valid when the output register is empty or draining.
// Backpressure: in_ready = skid register empty (registered, no combinational path from out_ready).
// Ports: in_valid/in_ready/opcode/fn_code upstream; out_valid/out_ready and decoded controls downstream;
//        flush discards held entries; ill_count counts accepted illegal instructions (not cleared by flush).
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int              OP_W     = 6,
    parameter int              FN_W     = 6,
    parameter int              ALU_CW   = 3,
    parameter logic [OP_W-1:0] RTYPE_OP = 6'b111111,
    parameter int              CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FN_W-1:0]   fn_code,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              reg_write,
    output logic              alu_to_reg,
    output logic              alu_op,
    output logic [ALU_CW-1:0] alu_cntrl,
    output logic              illegal,
    output logic [CNT_W-1:0]  ill_count
);

    ctrl_word_t         dec_word;
    ctrl_word_t         out_q, out_d;
    ctrl_word_t         skid_q, skid_d;
    occ_t               state_q, state_d;
    logic               accept;
    logic               drain;
    logic [CNT_W-1:0]   cnt_q;

    ctrl_decode #(
        .OP_W     (OP_W),
        .FN_W     (FN_W),
        .RTYPE_OP (RTYPE_OP)
    ) u_decode (
        .opcode  (opcode),
        .fn_code (fn_code),
        .word    (dec_word)
    );

    // Both handshake signals come straight from the state register.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over any same-cycle accept or drain.
            state_d = ST_EMPTY;
            out_d   = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        out_d   = dec_word;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_d = dec_word;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_d  = dec_word;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        state_d = ST_ONE;
                        out_d   = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && !flush && dec_word.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign reg_write  = out_q.reg_write;
    assign alu_to_reg = out_q.alu_to_reg;
    assign alu_op     = out_q.alu_op;
    assign alu_cntrl  = ALU_CW'(out_q.alu_cntrl);
    assign illegal    = out_q.illegal;
    assign ill_count  = cnt_q;

endmodule
